sid_reg_sequencer: RTL and testbench

Timed register-write sequencer on the host side of the SID register bus. It accepts a stream of commands over a valid/ready handshake and buffers them in a FIFO. Each command is either a register write or a wait of N clkEn ticks. It drives the single-cycle `iWE`/`iAddr`/`iData` write port shared by `sid_voices` and the rest of the SID, paced so that at most one write lands per 1 MHz tick.

---
 rtl/sid_pkg.sv | 26 ++
 rtl/sid_reg_sequencer_if.sv | 15 +
 rtl/sid_cmd_fifo.sv | 60 ++++++
 rtl/sid_reg_sequencer.sv | 140 ++++++++++++++
 tb/tb_sid_reg_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the SID register-write sequencer: command word layout,
// command kind encodings, highest legal register address and the FSM state type.
package sid_pkg;

  localparam int CMD_W        = 16;
  localparam int CMD_KIND_BIT = 15;
  localparam int ADDR_HI      = 12;
  localparam int ADDR_LO      = 8;
  localparam int DATA_HI      = 7;
  localparam int DATA_LO      = 0;
  localparam int ADDR_W       = ADDR_HI - ADDR_LO + 1;
  localparam int DATA_W       = DATA_HI - DATA_LO + 1;
  localparam int WAIT_W       = 15;

  localparam logic CMD_WRITE  = 1'b0;
  localparam logic CMD_WAIT   = 1'b1;

  localparam int SID_REG_MAX  = 'h18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sid_reg_sequencer_if.sv
// Command handshake from the host plus the single-cycle SID register write port.
interface sid_reg_sequencer_if;
  import sid_pkg::*;

  logic              iValid;
  logic              oReady;
  logic [CMD_W-1:0]  iCmd;
  logic              oWE;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oData;

  modport master (output iValid, iCmd, input oReady, oWE, oAddr, oData);
  modport slave  (input iValid, iCmd, output oReady, oWE, oAddr, oData);

endinterface

// File: rtl/sid_cmd_fifo.sv
// Single-clock command FIFO with show-ahead read, synchronous flush and
// an extra pointer bit to tell full from empty.
module sid_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign rdata   = mem[rptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sid_reg_sequencer.sv
// Timed SID register-write sequencer: pops buffered write/wait commands and
// drives at most one register write per clkEn tick onto the SID bus.
module sid_reg_sequencer
  import sid_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int REG_MAX = SID_REG_MAX
) (
  input  logic                   clk,
  input  logic                   iRstN,
  input  logic                   clkEn,
  input  logic                   iFlush,
  sid_reg_sequencer_if.slave     bus,
  output logic                   oBusy,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic [7:0]             oDropCnt
);

  localparam logic [ADDR_W-1:0] REG_MAX_A = ADDR_W'(REG_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CMD_W-1:0]  fifo_head;

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        drop_q, drop_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  // oReady depends only on registered FIFO state and the flush input
  assign bus.oReady = !fifo_full && !iFlush;
  assign fifo_push  = bus.iValid && bus.oReady;
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty && !iFlush;

  sid_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (iRstN),
    .flush (iFlush),
    .push  (fifo_push),
    .wdata (bus.iCmd),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (oLevel)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    drop_d      = drop_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (iFlush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (fifo_head[CMD_KIND_BIT])
              CMD_WRITE: begin
                if (fifo_head[ADDR_HI:ADDR_LO] > REG_MAX_A) begin
                  drop_d = sat_inc(drop_q);
                end else begin
                  pend_addr_d = fifo_head[ADDR_HI:ADDR_LO];
                  pend_data_d = fifo_head[DATA_HI:DATA_LO];
                  state_d     = ST_ISSUE;
                end
              end
              CMD_WAIT: begin
                if (fifo_head[WAIT_W-1:0] != '0) begin
                  cnt_d   = fifo_head[WAIT_W-1:0];
                  state_d = ST_WAIT;
                end
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (clkEn) begin
            we_d    = 1'b1;
            addr_d  = pend_addr_q;
            data_d  = pend_data_q;
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (clkEn) begin
            cnt_d = cnt_q - WAIT_ONE;
            if (cnt_q == WAIT_ONE) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  // Pending write payload is only consumed from ISSUE, so it needs no reset
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
  end

  assign bus.oWE   = we_q;
  assign bus.oAddr = addr_q;
  assign bus.oData = data_q;
  assign oDropCnt  = drop_q;
  assign oBusy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Bench for sid_reg_sequencer: vector table, directed multi-cycle sequences and
// a randomized command stream checked against an in-bench reference model.
module tb_sid_reg_sequencer;
  import sid_pkg::*;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             iRstN = 1'b0;
  logic             clkEn = 1'b0;
  logic             iFlush = 1'b0;
  logic             oBusy;
  logic [LVL_W-1:0] oLevel;
  logic [7:0]       oDropCnt;

  sid_reg_sequencer_if bus();

  sid_reg_sequencer #(.DEPTH(DEPTH), .REG_MAX('h18)) dut (
    .clk      (clk),
    .iRstN    (iRstN),
    .clkEn    (clkEn),
    .iFlush   (iFlush),
    .bus      (bus),
    .oBusy    (oBusy),
    .oLevel   (oLevel),
    .oDropCnt (oDropCnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] a; logic [7:0] d; int tick; int edge_i;} wr_t;
  typedef struct {logic [4:0] a; logic [7:0] d; int gap;} exp_t;
  typedef struct {logic [15:0] cmd; int we; logic [4:0] a; logic [7:0] d; int drops;} vec_t;

  wr_t got[$];
  int  edge_n = 0;
  int  tick_n = 0;
  int  en_mode = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  // Write monitor: count edges and clkEn ticks, log every strobe
  always @(posedge clk) begin
    edge_n++;
    if (clkEn) tick_n++;
    #1;
    if (bus.oWE) got.push_back('{bus.oAddr, bus.oData, tick_n, edge_n});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    case (en_mode)
      0:       clkEn = 1'b0;
      1:       clkEn = 1'b1;
      2:       clkEn = ((edge_n + 1) % 4 == 0);
      default: clkEn = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  task automatic push(input logic [15:0] cmd, output int acc_edge);
    int k;
    k = 0;
    bus.iCmd   = cmd;
    bus.iValid = 1'b1;
    while (!bus.oReady && k < 300) begin
      step();
      k++;
    end
    if (k == 300) check("push_ready_timeout", {31'd0, bus.oReady}, 32'd1);
    step();
    acc_edge   = edge_n;
    bus.iValid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    step();
    while (oBusy && k < budget) begin
      step();
      k++;
    end
    step();
    check(name, {31'd0, oBusy}, 32'd0);
  endtask

  vec_t vt[10];
  exp_t exp_q[$];

  initial begin
    int t, e, n0, acc, base, waits, exp_drops;
    logic [15:0] c;
    logic [4:0]  a;
    logic [7:0]  d;

    vt[0] = '{16'h0441, 1, 5'h04, 8'h41, 0};
    vt[1] = '{16'h180F, 1, 5'h18, 8'h0F, 0};
    vt[2] = '{16'h1D55, 0, 5'h00, 8'h00, 1};
    vt[3] = '{16'h6305, 1, 5'h03, 8'h05, 0};
    vt[4] = '{16'h8000, 0, 5'h00, 8'h00, 0};
    vt[5] = '{16'h8002, 0, 5'h00, 8'h00, 0};
    vt[6] = '{16'h1FAA, 0, 5'h00, 8'h00, 1};
    vt[7] = '{16'h00FF, 1, 5'h00, 8'hFF, 0};
    vt[8] = '{16'h7819, 1, 5'h18, 8'h19, 0};
    vt[9] = '{16'h1900, 0, 5'h00, 8'h00, 1};

    bus.iValid = 1'b0;
    bus.iCmd   = '0;
    en_mode    = 0;
    repeat (3) step();
    check("rst_we",    {31'd0, bus.oWE}, 32'd0);
    check("rst_addr",  {27'd0, bus.oAddr}, 32'd0);
    check("rst_data",  {24'd0, bus.oData}, 32'd0);
    check("rst_level", 32'(oLevel), 32'd0);
    check("rst_busy",  {31'd0, oBusy}, 32'd0);
    check("rst_drop",  {24'd0, oDropCnt}, 32'd0);
    iRstN = 1'b1;
    step();
    check("rst_ready", {31'd0, bus.oReady}, 32'd1);

    // Single write: strobe on first tick at least two edges after the push
    en_mode = 2;
    step();
    n0 = got.size();
    push(16'h0441, t);
    check("t1_level_after_push", 32'(oLevel), 32'd1);
    wait_idle("t1_idle", 100);
    check("t1_count", 32'(got.size() - n0), 32'd1);
    e = t + 2;
    while (e % 4 != 0) e++;
    if (got.size() > n0) begin
      check("t1_addr", {27'd0, got[n0].a}, 32'h04);
      check("t1_data", {24'd0, got[n0].d}, 32'h41);
      check("t1_edge", 32'(got[n0].edge_i), 32'(e));
    end
    check("t1_level", 32'(oLevel), 32'd0);

    // Vector table, one command at a time from idle
    for (int i = 0; i < 10; i++) begin
      n0   = got.size();
      base = oDropCnt;
      push(vt[i].cmd, t);
      wait_idle($sformatf("vec%0d_idle", i), 200);
      check($sformatf("vec%0d_we", i), 32'(got.size() - n0), 32'(vt[i].we));
      check($sformatf("vec%0d_drop", i), 32'(8'(oDropCnt - 8'(base))), 32'(vt[i].drops));
      if (vt[i].we == 1 && got.size() > n0) begin
        check($sformatf("vec%0d_addr", i), {27'd0, got[n0].a}, {27'd0, vt[i].a});
        check($sformatf("vec%0d_data", i), {24'd0, got[n0].d}, {24'd0, vt[i].d});
      end
    end

    // Wait 3 between writes spaces them 4 ticks; wait 0 adds nothing
    n0 = got.size();
    push(16'h0011, t);
    push(16'h8003, t);
    push(16'h0122, t);
    wait_idle("t2_idle", 200);
    check("t2_count", 32'(got.size() - n0), 32'd2);
    if (got.size() >= n0 + 2)
      check("t2_gap", 32'(got[n0+1].tick - got[n0].tick), 32'd4);
    n0 = got.size();
    push(16'h0233, t);
    push(16'h8000, t);
    push(16'h0344, t);
    wait_idle("t2b_idle", 200);
    check("t2b_count", 32'(got.size() - n0), 32'd2);
    if (got.size() >= n0 + 2)
      check("t2b_gap", 32'(got[n0+1].tick - got[n0].tick), 32'd1);

    // Fill with clkEn low: one entry sits in the command register, DEPTH in the FIFO
    en_mode = 0;
    step();
    n0  = got.size();
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.iCmd   = {3'b000, 5'(i % 25), 8'(8'hA0 + i)};
      bus.iValid = 1'b1;
      if (bus.oReady) acc++;
      step();
    end
    bus.iValid = 1'b0;
    check("full_accepts", 32'(acc), 32'(DEPTH + 1));
    check("full_level", 32'(oLevel), 32'(DEPTH));
    check("full_ready", {31'd0, bus.oReady}, 32'd0);
    check("full_no_we", 32'(got.size() - n0), 32'd0);
    en_mode = 2;
    wait_idle("full_idle", 600);
    check("full_count", 32'(got.size() - n0), 32'(DEPTH + 1));
    for (int i = 0; i <= DEPTH; i++) begin
      if (got.size() > n0 + i) begin
        check($sformatf("full_addr%0d", i), {27'd0, got[n0+i].a}, 32'(i % 25));
        check($sformatf("full_data%0d", i), {24'd0, got[n0+i].d}, 32'(8'(8'hA0 + i)));
        if (i > 0)
          check($sformatf("full_tick%0d", i), 32'(got[n0+i].tick - got[n0+i-1].tick), 32'd1);
      end
    end

    // Out-of-range write dropped, the following legal one issues
    n0   = got.size();
    base = oDropCnt;
    push(16'h1D77, t);
    push(16'h180F, t);
    wait_idle("drop_idle", 200);
    check("drop_cnt", 32'(8'(oDropCnt - 8'(base))), 32'd1);
    check("drop_count", 32'(got.size() - n0), 32'd1);
    if (got.size() > n0) begin
      check("drop_addr", {27'd0, got[n0].a}, 32'h18);
      check("drop_data", {24'd0, got[n0].d}, 32'h0F);
    end

    // Randomized stream against the reference model
    en_mode   = 3;
    n0        = got.size();
    base      = oDropCnt;
    waits     = 0;
    exp_drops = 0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        c = 16'($urandom()) & 16'h7FFF;
        a = c[12:8];
        d = c[7:0];
        if (a > 5'h18) exp_drops++;
        else begin
          exp_q.push_back('{a, d, waits});
          waits = 0;
        end
      end else begin
        c = 16'h8000 | 16'($urandom_range(0, 5));
        waits += int'(c[14:0]);
      end
      push(c, t);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle("rnd_idle", 3000);
    check("rnd_count", 32'(got.size() - n0), 32'(exp_q.size()));
    check("rnd_drops", 32'(8'(oDropCnt - 8'(base))), 32'(exp_drops));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (got.size() > n0 + k) begin
        check($sformatf("rnd_addr%0d", k), {27'd0, got[n0+k].a}, {27'd0, exp_q[k].a});
        check($sformatf("rnd_data%0d", k), {24'd0, got[n0+k].d}, {24'd0, exp_q[k].d});
        check($sformatf("rnd_gap%0d", k),
              {31'd0, (got[n0+k].tick - got[n0+k-1].tick) >= exp_q[k].gap + 1}, 32'd1);
      end
    end

    // Flush during a long wait with three writes queued and a push attempted
    en_mode = 2;
    push(16'h8064, t);
    push(16'h0501, t);
    push(16'h0602, t);
    push(16'h0703, t);
    repeat (2) step();
    check("fl_level_pre", 32'(oLevel), 32'd3);
    check("fl_busy_pre", {31'd0, oBusy}, 32'd1);
    n0 = got.size();
    iFlush     = 1'b1;
    bus.iValid = 1'b1;
    bus.iCmd   = 16'h0804;
    #1;
    check("fl_ready", {31'd0, bus.oReady}, 32'd0);
    step();
    iFlush     = 1'b0;
    bus.iValid = 1'b0;
    check("fl_level", 32'(oLevel), 32'd0);
    check("fl_busy", {31'd0, oBusy}, 32'd0);
    repeat (60) step();
    check("fl_no_we", 32'(got.size() - n0), 32'd0);
    check("fl_level_end", 32'(oLevel), 32'd0);

    // Asynchronous reset while a write is stalled in ISSUE
    en_mode = 0;
    step();
    push(16'h0912, t);
    repeat (3) step();
    check("ar_busy_pre", {31'd0, oBusy}, 32'd1);
    #3;
    iRstN = 1'b0;
    #1;
    check("ar_we",    {31'd0, bus.oWE}, 32'd0);
    check("ar_addr",  {27'd0, bus.oAddr}, 32'd0);
    check("ar_data",  {24'd0, bus.oData}, 32'd0);
    check("ar_level", 32'(oLevel), 32'd0);
    check("ar_busy",  {31'd0, oBusy}, 32'd0);
    check("ar_drop",  {24'd0, oDropCnt}, 32'd0);
    step();
    iRstN   = 1'b1;
    en_mode = 2;
    n0 = got.size();
    repeat (30) step();
    check("ar_no_we", 32'(got.size() - n0), 32'd0);
    check("ar_busy_post", {31'd0, oBusy}, 32'd0);
    check("ar_ready_post", {31'd0, bus.oReady}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
